alu_ctrl_fsm: RTL and testbench

ALU_CTRL_FSM -- requirements
Module: alu_ctrl_fsm

---
 rtl/alu_ctrl_pkg.sv | 49 ++++
 rtl/alu_ctrl_fsm_alu_op_decode.sv | 20 ++
 rtl/alu_ctrl_fsm.sv | 126 ++++++++++++
 tb/tb_alu_ctrl_fsm.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the accumulator CPU: opcode, ALU operation and
// controller state codes, plus the bundle of control strobes.
package alu_ctrl_pkg;

  localparam int OPC_WIDTH = 3;

  typedef enum logic [2:0] {
    OP_LDA = 3'd0,
    OP_STA = 3'd1,
    OP_ADD = 3'd2,
    OP_SUB = 3'd3,
    OP_AND = 3'd4,
    OP_NOT = 3'd5,
    OP_JMP = 3'd6,
    OP_JZ  = 3'd7
  } opcode_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  localparam logic [1:0] SRCB_MDR = 2'b00;
  localparam logic [1:0] SRCB_ONE = 2'b01;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_MEM_RD = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM_WR = 3'd4
  } state_e;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       acc_write;
    logic       z_write;
    logic       pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       acc_src;
  } ctrl_t;

endpackage

// File: rtl/alu_ctrl_fsm_alu_op_decode.sv
// Maps an instruction opcode to the ALU operation it needs in EXEC.
module alu_op_decode
  import alu_ctrl_pkg::*;
(
  input  opcode_e    opcode,
  output logic [1:0] alu_op
);

  // LDA passes MDR through the adder path; non-EXEC opcodes default to add.
  always_comb begin
    alu_op = ALU_ADD;
    case (opcode)
      OP_SUB:  alu_op = ALU_SUB;
      OP_AND:  alu_op = ALU_AND;
      OP_NOT:  alu_op = ALU_NOT;
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle control FSM for a single-accumulator CPU: fetch, decode,
// optional memory access, execute. Strobes are combinational from state.
module alu_ctrl_fsm
  import alu_ctrl_pkg::*;
#(
  parameter int OPC_W = OPC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero_flag,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             acc_write,
  output logic             z_write,
  output logic             pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             acc_src,
  output logic [2:0]       state_o
);

  state_e     state_q, state_d;
  opcode_e    opc;
  logic [1:0] exec_alu_op;
  ctrl_t      ctrl;

  assign opc = opcode_e'(opcode);

  alu_op_decode u_alu_op_decode (
    .opcode (opc),
    .alu_op (exec_alu_op)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opc)
          OP_JMP, OP_JZ: state_d = S_FETCH;
          OP_NOT:        state_d = S_EXEC;
          OP_STA:        state_d = S_MEM_WR;
          default:       state_d = S_MEM_RD;
        endcase
      end
      S_MEM_RD: if (mem_ready) state_d = S_EXEC;
      S_EXEC:   state_d = S_FETCH;
      S_MEM_WR: if (mem_ready) state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Reset gates every strobe so an instruction in flight is abandoned at once.
  always_comb begin
    ctrl = '0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          ctrl.mem_read = 1'b1;
          if (mem_ready) begin
            ctrl.ir_write  = 1'b1;
            ctrl.pc_write  = 1'b1;
            ctrl.alu_src_b = SRCB_ONE;
            ctrl.alu_op    = ALU_ADD;
          end
        end
        S_DECODE: begin
          case (opc)
            OP_JMP: begin
              ctrl.pc_write = 1'b1;
              ctrl.pc_src   = 1'b1;
            end
            OP_JZ: begin
              ctrl.pc_write = zero_flag;
              ctrl.pc_src   = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM_RD: begin
          ctrl.mem_read = 1'b1;
          ctrl.iord     = 1'b1;
        end
        S_EXEC: begin
          ctrl.acc_write = 1'b1;
          ctrl.z_write   = 1'b1;
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_MDR;
          ctrl.alu_op    = exec_alu_op;
          ctrl.acc_src   = (opc == OP_LDA);
        end
        S_MEM_WR: begin
          ctrl.mem_write = 1'b1;
          ctrl.iord      = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mem_read  = ctrl.mem_read;
  assign mem_write = ctrl.mem_write;
  assign iord      = ctrl.iord;
  assign ir_write  = ctrl.ir_write;
  assign pc_write  = ctrl.pc_write;
  assign acc_write = ctrl.acc_write;
  assign z_write   = ctrl.z_write;
  assign pc_src    = ctrl.pc_src;
  assign alu_src_a = ctrl.alu_src_a;
  assign alu_src_b = ctrl.alu_src_b;
  assign alu_op    = ctrl.alu_op;
  assign acc_src   = ctrl.acc_src;
  assign state_o   = state_q;

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Scoreboard bench: each issued instruction pushes an expected per-instruction
// summary; a monitor rebuilds the observed summary and compares.
module tb_alu_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] opcode;
  logic       zero_flag, mem_ready;
  logic       mem_read, mem_write, iord, ir_write, pc_write, acc_write, z_write;
  logic       pc_src, alu_src_a, acc_src;
  logic [1:0] alu_src_b, alu_op;
  logic [2:0] state_o;

  int vectors = 0;
  int miscompares = 0;
  bit monEn = 1'b0;

  typedef struct {
    int cycles;
    int ir_w;
    int pc_w;
    int pc_inc;
    int acc_w;
    int z_w;
    int rd_cyc;
    int wr_cyc;
    int iord_cyc;
    int pcsrc_cyc;
    int both;
    int exec_op;
    int exec_accsrc;
    int exec_sel;
    int path;
  } rec_t;

  rec_t expQ[$];

  alu_ctrl_fsm #(.OPC_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .zero_flag (zero_flag),
    .mem_ready (mem_ready),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .iord      (iord),
    .ir_write  (ir_write),
    .pc_write  (pc_write),
    .acc_write (acc_write),
    .z_write   (z_write),
    .pc_src    (pc_src),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .alu_op    (alu_op),
    .acc_src   (acc_src),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: what one whole instruction should look like from outside.
  function automatic rec_t modelInstr(input int op, input int z, input int fw, input int mw);
    rec_t r;
    int   aluTab[8];
    int   states[$];
    bit   isJ, isNot, isSta, isRd, hasExec;
    aluTab = '{0, 0, 0, 1, 2, 3, 0, 0};
    r = '{default: 0};
    isJ     = (op == 6) || (op == 7);
    isNot   = (op == 5);
    isSta   = (op == 1);
    isRd    = (op == 0) || (op == 2) || (op == 3) || (op == 4);
    hasExec = isRd || isNot;
    r.cycles   = (isJ ? 2 : ((isNot || isSta) ? 3 : 4)) + fw + ((isRd || isSta) ? mw : 0);
    r.ir_w     = 1;
    r.pc_inc   = 1;
    r.pc_w     = 1 + ((op == 6) ? 1 : ((op == 7) ? z : 0));
    r.pcsrc_cyc = isJ ? 1 : 0;
    r.acc_w    = hasExec ? 1 : 0;
    r.z_w      = hasExec ? 1 : 0;
    r.rd_cyc   = fw + 1 + (isRd ? mw + 1 : 0);
    r.wr_cyc   = isSta ? mw + 1 : 0;
    r.iord_cyc = (isRd || isSta) ? mw + 1 : 0;
    r.both     = 0;
    r.exec_op     = hasExec ? aluTab[op] : 0;
    r.exec_accsrc = (op == 0) ? 1 : 0;
    r.exec_sel    = hasExec ? 4 : 0;
    states = {0, 1};
    if (isRd)  states.push_back(2);
    if (hasExec) states.push_back(3);
    if (isSta) states.push_back(4);
    foreach (states[i]) r.path = r.path * 8 + states[i] + 1;
    return r;
  endfunction

  task automatic closeRecord(input rec_t a);
    rec_t e;
    if (expQ.size() == 0) begin
      checkOutput("unexpected_instr", 1, 0);
      return;
    end
    e = expQ.pop_front();
    checkOutput("cycles",      a.cycles,      e.cycles);
    checkOutput("ir_write",    a.ir_w,        e.ir_w);
    checkOutput("pc_write",    a.pc_w,        e.pc_w);
    checkOutput("pc_inc",      a.pc_inc,      e.pc_inc);
    checkOutput("acc_write",   a.acc_w,       e.acc_w);
    checkOutput("z_write",     a.z_w,         e.z_w);
    checkOutput("mem_read",    a.rd_cyc,      e.rd_cyc);
    checkOutput("mem_write",   a.wr_cyc,      e.wr_cyc);
    checkOutput("iord",        a.iord_cyc,    e.iord_cyc);
    checkOutput("pc_src",      a.pcsrc_cyc,   e.pcsrc_cyc);
    checkOutput("rd_wr_both",  a.both,        e.both);
    checkOutput("exec_alu_op", a.exec_op,     e.exec_op);
    checkOutput("exec_accsrc", a.exec_accsrc, e.exec_accsrc);
    checkOutput("exec_alusel", a.exec_sel,    e.exec_sel);
    checkOutput("state_path",  a.path,        e.path);
  endtask

  rec_t       cur;
  bit         recOpen = 1'b0;
  logic [2:0] prevState = 3'd7;

  // A record spans from the first FETCH cycle to the cycle before the next one.
  always @(negedge clk) begin
    if (rst || !monEn) begin
      recOpen   = 1'b0;
      prevState = 3'd7;
    end else begin
      if (state_o == 3'd0 && prevState != 3'd0) begin
        if (recOpen) closeRecord(cur);
        cur     = '{default: 0};
        recOpen = 1'b1;
      end
      if (recOpen) begin
        cur.cycles++;
        if (state_o != prevState) cur.path = cur.path * 8 + int'(state_o) + 1;
        if (ir_write)  cur.ir_w++;
        if (pc_write)  cur.pc_w++;
        if (ir_write && pc_write && !pc_src && !alu_src_a && alu_src_b == 2'b01 && alu_op == 2'b00)
          cur.pc_inc++;
        if (acc_write) begin
          cur.acc_w++;
          cur.exec_op     = int'(alu_op);
          cur.exec_accsrc = int'(acc_src);
          cur.exec_sel    = int'({alu_src_a, alu_src_b});
        end
        if (z_write)   cur.z_w++;
        if (mem_read)  cur.rd_cyc++;
        if (mem_write) cur.wr_cyc++;
        if (iord)      cur.iord_cyc++;
        if (pc_src)    cur.pcsrc_cyc++;
        if (mem_read && mem_write) cur.both++;
      end
      prevState = state_o;
    end
  end

  // Drives one instruction open-loop: fw fetch waits, mw memory-phase waits.
  task automatic applyStimulus(input int op, input int z, input int fw, input int mw);
    bit memPhase, execPhase;
    expQ.push_back(modelInstr(op, z, fw, mw));
    memPhase  = (op <= 4);
    execPhase = (op == 0) || (op >= 2 && op <= 5);
    opcode    = 3'(op);
    zero_flag = z[0];
    for (int i = 0; i < fw; i++) begin
      mem_ready = 1'b0;
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    if (memPhase) begin
      for (int i = 0; i < mw; i++) begin
        mem_ready = 1'b0;
        @(posedge clk); #1;
      end
      mem_ready = 1'b1;
      @(posedge clk); #1;
    end
    if (execPhase && op != 1) begin
      mem_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
  endtask

  function automatic int allOutputs();
    return int'({mem_read, mem_write, iord, ir_write, pc_write, acc_write, z_write,
                 pc_src, alu_src_a, alu_src_b, alu_op, acc_src});
  endfunction

  initial begin
    int fw, mw;
    bit reached;
    rst       = 1'b1;
    opcode    = 3'd2;
    zero_flag = 1'b1;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_outputs", allOutputs(), 0);
    checkOutput("reset_state", int'(state_o), 0);

    @(posedge clk); #1;
    rst       = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    checkOutput("first_fetch_read", int'(mem_read), 1);
    checkOutput("fetch_wait_state", int'(state_o), 0);
    checkOutput("fetch_wait_irw", int'(ir_write | pc_write), 0);

    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst   = 1'b0;
    monEn = 1'b1;

    for (int op = 0; op < 8; op++) applyStimulus(op, 1, 0, 0);
    applyStimulus(7, 0, 0, 0);
    applyStimulus(0, 0, 0, 3);
    applyStimulus(1, 0, 2, 1);
    for (int n = 0; n < 200; n++) begin
      fw = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
      mw = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
      applyStimulus(int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), fw, mw);
    end
    mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    monEn = 1'b0;
    checkOutput("scoreboard_left", expQ.size(), 0);

    opcode    = 3'd1;
    mem_ready = 1'b1;
    reached   = 1'b0;
    for (int i = 0; i < 10 && !reached; i++) begin
      @(posedge clk); #1;
      if (state_o == 3'd4) reached = 1'b1;
    end
    checkOutput("reach_mem_wr", int'(reached), 1);
    mem_ready = 1'b0;
    #1;
    checkOutput("mem_wr_strobe", int'(mem_write & iord), 1);
    rst = 1'b1;
    #1;
    checkOutput("async_drop_mem_write", int'(mem_write), 0);
    checkOutput("async_drop_outputs", allOutputs(), 0);
    checkOutput("async_reset_state", int'(state_o), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checkOutput("post_reset_fetch", int'(state_o), 0);
    checkOutput("post_reset_read", int'({mem_read, mem_write}), 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
